// File: rtl/cd_pkg.sv
//------------------------------------------------------------------------------
// cd_pkg
// Shared constants for the CD host-side register responder: HIRQ bit indices,
// register offsets within the CS2 page, command opcodes, reset signature values
// and the command FSM state type. Also holds small byte-lane helpers.
//------------------------------------------------------------------------------
package cd_pkg;

   // HIRQ flag bit positions
   localparam int unsigned HIRQ_CMOK = 0;
   localparam int unsigned HIRQ_DRDY = 1;
   localparam int unsigned HIRQ_CSCT = 2;
   localparam int unsigned HIRQ_BFUL = 3;
   localparam int unsigned HIRQ_PEND = 4;
   localparam int unsigned HIRQ_DCHG = 5;
   localparam int unsigned HIRQ_ESEL = 6;
   localparam int unsigned HIRQ_EHST = 7;

   // A-bus page (AA[25:16]) that selects this block
   localparam logic [9:0] CD_PAGE = 10'h189;

   // Word offsets inside the page
   localparam logic [15:0] OFS_HIRQ     = 16'h0008;
   localparam logic [15:0] OFS_HIRQMASK = 16'h000C;
   localparam logic [15:0] OFS_CR1      = 16'h0018;
   localparam logic [15:0] OFS_CR2      = 16'h001C;
   localparam logic [15:0] OFS_CR3      = 16'h0020;
   localparam logic [15:0] OFS_CR4      = 16'h0024;

   // Command opcodes (CMD1[15:8])
   localparam logic [7:0] OP_GET_STATUS  = 8'h00;
   localparam logic [7:0] OP_GET_HW_INFO = 8'h01;
   localparam logic [7:0] OP_GET_TOC     = 8'h02;
   localparam logic [7:0] OP_ABORT_FILE  = 8'h75;

   // Drive status byte (PAUSE) and the periodic-report marker bit
   localparam logic [7:0] CD_STATUS     = 8'h01;
   localparam logic [7:0] CD_PERIODIC   = 8'h20;

   // Reset signature ("CDBLOCK" in the response registers)
   localparam logic [15:0] RR1_RST      = 16'h0043;
   localparam logic [15:0] RR2_RST      = 16'h4442;
   localparam logic [15:0] RR3_RST      = 16'h4C4F;
   localparam logic [15:0] RR4_RST      = 16'h434B;
   localparam logic [7:0]  HIRQ_RST     = 8'h01;
   localparam logic [15:0] HIRQMASK_RST = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EXEC = 2'd2
   } cd_state_e;

   // One-hot mask for a HIRQ bit index
   function automatic logic [7:0] hirq_bit(input int unsigned idx);
      return 8'h01 << idx;
   endfunction

   // Merge new data into an old word, byte lane by byte lane
   function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic        hi,
                                              input logic        lo);
      return {(hi ? new_v[15:8] : old_v[15:8]), (lo ? new_v[7:0] : old_v[7:0])};
   endfunction

endpackage

// File: rtl/cd_abus_if.sv
//------------------------------------------------------------------------------
// cd_abus_if
// SCU A-bus slice seen by the CD block (CS2 space).
//   ACS2_N  chip select (active low)       AA      address [25:1]
//   AWRU_N  upper-byte write strobe        AWRL_N  lower-byte write strobe
//   ARD_N   read strobe                    DI      host write data
//   DO      read data back to the host     AIRQ_N  interrupt to the SCU
// master = host side, slave = CD block.
//------------------------------------------------------------------------------
interface cd_abus_if;
   logic        ACS2_N;
   logic [25:1] AA;
   logic        AWRU_N;
   logic        AWRL_N;
   logic        ARD_N;
   logic [15:0] DI;
   logic [15:0] DO;
   logic        AIRQ_N;

   modport master (
      output ACS2_N, AA, AWRU_N, AWRL_N, ARD_N, DI,
      input  DO, AIRQ_N
   );

   modport slave (
      input  ACS2_N, AA, AWRU_N, AWRL_N, ARD_N, DI,
      output DO, AIRQ_N
   );
endinterface

// File: rtl/cd_cmd_exec.sv
//------------------------------------------------------------------------------
// cd_cmd_exec
// Combinational command decoder: maps the opcode in CMD1[15:8] to the response
// words RR1-RR4 and the HIRQ bits to set when the command completes.
//   opcode    in  8   command opcode
//   rr1..rr4  out 16  response register values
//   hirq_set  out 8   HIRQ bits raised on completion
//------------------------------------------------------------------------------
module cd_cmd_exec
   import cd_pkg::*;
(
   input  logic [7:0]  opcode,
   output logic [15:0] rr1,
   output logic [15:0] rr2,
   output logic [15:0] rr3,
   output logic [15:0] rr4,
   output logic [7:0]  hirq_set
);

   // Opcode decode; unknown opcodes are rejected with 0xFF in RR1's high byte
   always_comb begin
      rr1      = {CD_STATUS, 8'h00};
      rr2      = 16'h0000;
      rr3      = 16'h0000;
      rr4      = 16'h0000;
      hirq_set = hirq_bit(HIRQ_CMOK);
      case (opcode)
         OP_GET_STATUS: begin
            rr1 = {CD_STATUS, 8'h00};
         end
         OP_GET_HW_INFO: begin
            rr2 = 16'h0002;
            rr4 = 16'h0600;
         end
         OP_GET_TOC: begin
            rr2      = 16'h00CC;
            hirq_set = hirq_bit(HIRQ_CMOK) | hirq_bit(HIRQ_DRDY);
         end
         OP_ABORT_FILE: begin
            hirq_set = hirq_bit(HIRQ_CMOK) | hirq_bit(HIRQ_EHST);
         end
         default: begin
            rr1 = 16'hFF00;
         end
      endcase
   end

endmodule

// File: rtl/cd_host_if.sv
//------------------------------------------------------------------------------
// cd_host_if
// Host-side register responder for the CD block (CS2 page 0x189). The host
// writes CR1-CR4; a CR4 write starts a command that completes CMD_LATENCY+1
// enabled cycles later, loading RR1-RR4 and raising HIRQ flags. While idle
// with CMOK set, a periodic status report refreshes RR1.
//   CLK     in   clock                 RST    in   async active-high reset
//   CE_R    in   clock enable          bus    slave modport of cd_abus_if
//   BUSY    out  command in progress (registered)
//------------------------------------------------------------------------------
module cd_host_if
   import cd_pkg::*;
#(
   parameter int unsigned CMD_LATENCY   = 16,
   parameter int unsigned REPORT_PERIOD = 4096
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   cd_abus_if.slave   bus,
   output logic       BUSY
);

   localparam int unsigned LAT_W = (CMD_LATENCY > 1) ? $clog2(CMD_LATENCY) : 1;
   localparam int unsigned RPT_W = $clog2(REPORT_PERIOD);

   cd_state_e          state_r;
   logic [LAT_W-1:0]   lat_r;
   logic [RPT_W-1:0]   rpt_r;
   logic               busy_r;
   logic [7:0]         hirq_r;
   logic [15:0]        hirq_mask_r;
   logic [15:0]        cmd1_r, cmd2_r, cmd3_r, cmd4_r;
   logic [15:0]        rr1_r, rr2_r, rr3_r, rr4_r;

   logic               sel_s, wr_hi_s, wr_lo_s, wr_s, cr4_wr_s, start_s, rpt_wrap_s;
   logic [15:0]        ofs_s;
   logic [15:0]        do_s;
   logic [7:0]         hirq_keep_s, hirq_nxt_s;
   logic [15:0]        ex_rr1_s, ex_rr2_s, ex_rr3_s, ex_rr4_s;
   logic [7:0]         ex_set_s;
   logic               unused_s;

   assign sel_s      = !bus.ACS2_N && (bus.AA[25:16] == CD_PAGE);
   assign ofs_s      = {bus.AA[15:1], 1'b0};
   assign wr_hi_s    = sel_s && !bus.AWRU_N;
   assign wr_lo_s    = sel_s && !bus.AWRL_N;
   assign wr_s       = wr_hi_s || wr_lo_s;
   assign cr4_wr_s   = wr_s && (ofs_s == OFS_CR4);
   assign start_s    = cr4_wr_s && (state_r == IDLE);
   assign rpt_wrap_s = (rpt_r == RPT_W'(REPORT_PERIOD - 1));

   // CMD2-CMD4 are latched for the host but no implemented command reads them
   assign unused_s   = ^{cmd2_r, cmd3_r, cmd4_r, bus.ARD_N};

   cd_cmd_exec u_exec (
      .opcode   (cmd1_r[15:8]),
      .rr1      (ex_rr1_s),
      .rr2      (ex_rr2_s),
      .rr3      (ex_rr3_s),
      .rr4      (ex_rr4_s),
      .hirq_set (ex_set_s)
   );

   // Next HIRQ: host AND-clear and command start clear first, completion set wins
   always_comb begin
      hirq_keep_s = 8'hFF;
      if (wr_lo_s && (ofs_s == OFS_HIRQ)) begin
         hirq_keep_s = bus.DI[7:0];
      end else begin
         hirq_keep_s = 8'hFF;
      end
      hirq_nxt_s = hirq_r & hirq_keep_s;
      if (start_s) begin
         hirq_nxt_s = hirq_nxt_s & ~hirq_bit(HIRQ_CMOK);
      end else begin
         hirq_nxt_s = hirq_nxt_s;
      end
      if (state_r == EXEC) begin
         hirq_nxt_s = hirq_nxt_s | ex_set_s;
      end else begin
         hirq_nxt_s = hirq_nxt_s;
      end
   end

   // Combinational read mux; the host expects data in the select cycle
   always_comb begin
      do_s = 16'h0000;
      if (sel_s) begin
         case (ofs_s)
            OFS_HIRQ:     do_s = {8'h00, hirq_r};
            OFS_HIRQMASK: do_s = hirq_mask_r;
            OFS_CR1:      do_s = rr1_r;
            OFS_CR2:      do_s = rr2_r;
            OFS_CR3:      do_s = rr3_r;
            OFS_CR4:      do_s = rr4_r;
            default:      do_s = 16'h0000;
         endcase
      end else begin
         do_s = 16'h0000;
      end
   end

   assign bus.DO     = do_s;
   assign bus.AIRQ_N = ~|(hirq_r & hirq_mask_r[7:0]);
   assign BUSY       = busy_r;

   // Register file, command FSM, latency and report counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= IDLE;
         lat_r       <= '0;
         rpt_r       <= '0;
         busy_r      <= 1'b0;
         hirq_r      <= HIRQ_RST;
         hirq_mask_r <= HIRQMASK_RST;
         cmd1_r      <= 16'h0000;
         cmd2_r      <= 16'h0000;
         cmd3_r      <= 16'h0000;
         cmd4_r      <= 16'h0000;
         rr1_r       <= RR1_RST;
         rr2_r       <= RR2_RST;
         rr3_r       <= RR3_RST;
         rr4_r       <= RR4_RST;
      end else if (CE_R) begin
         hirq_r <= hirq_nxt_s;

         if (wr_s) begin
            case (ofs_s)
               OFS_HIRQMASK: hirq_mask_r <= lane_merge(hirq_mask_r, bus.DI, wr_hi_s, wr_lo_s);
               OFS_CR1:      cmd1_r      <= lane_merge(cmd1_r, bus.DI, wr_hi_s, wr_lo_s);
               OFS_CR2:      cmd2_r      <= lane_merge(cmd2_r, bus.DI, wr_hi_s, wr_lo_s);
               OFS_CR3:      cmd3_r      <= lane_merge(cmd3_r, bus.DI, wr_hi_s, wr_lo_s);
               OFS_CR4:      cmd4_r      <= lane_merge(cmd4_r, bus.DI, wr_hi_s, wr_lo_s);
               default:      ;
            endcase
         end

         if (cr4_wr_s) begin
            rpt_r <= '0;
         end

         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= WAIT;
                  lat_r   <= LAT_W'(CMD_LATENCY - 1);
                  busy_r  <= 1'b1;
               end else if (hirq_r[HIRQ_CMOK]) begin
                  // Periodic report only touches RR1; a coincident CR4 write
                  // takes the branch above and suppresses it
                  if (rpt_wrap_s) begin
                     rpt_r <= '0;
                     rr1_r <= {(CD_PERIODIC | CD_STATUS), 8'h00};
                  end else begin
                     rpt_r <= rpt_r + RPT_W'(1);
                  end
               end
            end
            WAIT: begin
               if (lat_r == '0) begin
                  state_r <= EXEC;
               end else begin
                  lat_r <= lat_r - LAT_W'(1);
               end
            end
            EXEC: begin
               rr1_r   <= ex_rr1_s;
               rr2_r   <= ex_rr2_s;
               rr3_r   <= ex_rr3_s;
               rr4_r   <= ex_rr4_s;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cd_host_if.sv
//------------------------------------------------------------------------------
// tb_cd_host_if
// Directed, self-checking bench for cd_host_if. Inputs change just after the
// falling edge, the DUT samples on the rising edge, outputs are read between.
//------------------------------------------------------------------------------
module tb_cd_host_if;

   localparam int unsigned LAT = 4;
   localparam int unsigned PER = 64;

   localparam logic [9:0]  PAGE   = 10'h189;
   localparam logic [15:0] A_HIRQ = 16'h0008;
   localparam logic [15:0] A_MASK = 16'h000C;
   localparam logic [15:0] A_CR1  = 16'h0018;
   localparam logic [15:0] A_CR2  = 16'h001C;
   localparam logic [15:0] A_CR3  = 16'h0020;
   localparam logic [15:0] A_CR4  = 16'h0024;

   logic CLK;
   logic RST;
   logic CE_R;
   logic BUSY;
   int   tests_run;
   int   failed;

   cd_abus_if bus ();

   cd_host_if #(.CMD_LATENCY(LAT), .REPORT_PERIOD(PER)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .CE_R (CE_R),
      .bus  (bus),
      .BUSY (BUSY)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   task automatic wr(input logic [15:0] ofs, input logic [15:0] d, input logic [1:0] lanes);
      bus.ACS2_N = 1'b0;
      bus.AA     = {PAGE, ofs[15:1]};
      bus.DI     = d;
      bus.AWRU_N = ~lanes[1];
      bus.AWRL_N = ~lanes[0];
      @(negedge CLK);
      bus.ACS2_N = 1'b1;
      bus.AWRU_N = 1'b1;
      bus.AWRL_N = 1'b1;
   endtask

   task automatic rd_raw(input logic cs_n, input logic [25:1] aa, output logic [15:0] d);
      bus.ACS2_N = cs_n;
      bus.ARD_N  = 1'b0;
      bus.AA     = aa;
      #1;
      d = bus.DO;
      bus.ACS2_N = 1'b1;
      bus.ARD_N  = 1'b1;
   endtask

   task automatic rd(input logic [15:0] ofs, output logic [15:0] d);
      rd_raw(1'b0, {PAGE, ofs[15:1]}, d);
   endtask

   task automatic test_reset;
      logic [15:0] d;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h0043) begin failed++; $display("FAIL reset_rr1 got %h want %h", d, 16'h0043); end
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h4442) begin failed++; $display("FAIL reset_rr2 got %h want %h", d, 16'h4442); end
      rd(A_CR3, d); tests_run++;
      if (d !== 16'h4C4F) begin failed++; $display("FAIL reset_rr3 got %h want %h", d, 16'h4C4F); end
      rd(A_CR4, d); tests_run++;
      if (d !== 16'h434B) begin failed++; $display("FAIL reset_rr4 got %h want %h", d, 16'h434B); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0001) begin failed++; $display("FAIL reset_hirq got %h want %h", d, 16'h0001); end
      rd(A_MASK, d); tests_run++;
      if (d !== 16'hFFFF) begin failed++; $display("FAIL reset_mask got %h want %h", d, 16'hFFFF); end
      tests_run++;
      if (bus.AIRQ_N !== 1'b0) begin failed++; $display("FAIL reset_airq got %b want 0", bus.AIRQ_N); end
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", BUSY); end
   endtask

   task automatic test_hirq_clear;
      logic [15:0] d;
      wr(A_HIRQ, 16'hFFFE, 2'b11);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL hirq_clear got %h want %h", d, 16'h0000); end
      tests_run++;
      if (bus.AIRQ_N !== 1'b1) begin failed++; $display("FAIL hirq_clear_airq got %b want 1", bus.AIRQ_N); end
   endtask

   task automatic test_masked_status;
      logic [15:0] d;
      wr(A_MASK, 16'h0000, 2'b11);
      wr(A_CR1, 16'h0000, 2'b11);
      wr(A_CR2, 16'h0000, 2'b11);
      wr(A_CR3, 16'h0000, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      repeat (LAT) @(negedge CLK);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL status_early got %h want %h", d, 16'h0000); end
      @(negedge CLK);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0001) begin failed++; $display("FAIL status_hirq got %h want %h", d, 16'h0001); end
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h0100) begin failed++; $display("FAIL status_rr1 got %h want %h", d, 16'h0100); end
      tests_run++;
      if (bus.AIRQ_N !== 1'b1) begin failed++; $display("FAIL status_masked_airq got %b want 1", bus.AIRQ_N); end
      wr(A_MASK, 16'hFFFF, 2'b11);
      tests_run++;
      if (bus.AIRQ_N !== 1'b0) begin failed++; $display("FAIL status_unmasked_airq got %b want 0", bus.AIRQ_N); end
   endtask

   task automatic test_get_toc;
      logic [15:0] d;
      wr(A_CR1, 16'h0200, 2'b11);
      wr(A_CR2, 16'h0000, 2'b11);
      wr(A_CR3, 16'h0000, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      for (int k = 0; k <= LAT; k++) begin
         tests_run++;
         if (BUSY !== 1'b1) begin failed++; $display("FAIL toc_busy cycle %0d got %b want 1", k, BUSY); end
         rd(A_CR2, d); tests_run++;
         if (d !== 16'h0000) begin failed++; $display("FAIL toc_rr2_early cycle %0d got %h want %h", k, d, 16'h0000); end
         if (k < LAT) @(negedge CLK);
      end
      @(negedge CLK);
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h0100) begin failed++; $display("FAIL toc_rr1 got %h want %h", d, 16'h0100); end
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h00CC) begin failed++; $display("FAIL toc_rr2 got %h want %h", d, 16'h00CC); end
      rd(A_CR4, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL toc_rr4 got %h want %h", d, 16'h0000); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0003) begin failed++; $display("FAIL toc_hirq got %h want %h", d, 16'h0003); end
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL toc_busy_done got %b want 0", BUSY); end
   endtask

   task automatic test_periodic;
      logic [15:0] d;
      wr(A_CR1, 16'h0200, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      repeat (LAT + 1) @(negedge CLK);
      repeat (PER - 1) @(negedge CLK);
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h0100) begin failed++; $display("FAIL periodic_early got %h want %h", d, 16'h0100); end
      @(negedge CLK);
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h2100) begin failed++; $display("FAIL periodic_rr1 got %h want %h", d, 16'h2100); end
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h00CC) begin failed++; $display("FAIL periodic_rr2 got %h want %h", d, 16'h00CC); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0003) begin failed++; $display("FAIL periodic_hirq got %h want %h", d, 16'h0003); end
   endtask

   task automatic test_unknown_retrigger;
      logic [15:0] d;
      wr(A_HIRQ, 16'h0000, 2'b11);
      wr(A_CR1, 16'h5A00, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      wr(A_CR4, 16'h1234, 2'b11);
      repeat (LAT - 1) @(negedge CLK);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL unk_early_hirq got %h want %h", d, 16'h0000); end
      @(negedge CLK);
      rd(A_CR1, d); tests_run++;
      if (d !== 16'hFF00) begin failed++; $display("FAIL unk_rr1 got %h want %h", d, 16'hFF00); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0001) begin failed++; $display("FAIL unk_hirq got %h want %h", d, 16'h0001); end
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL retrigger_busy got %b want 0", BUSY); end
      @(negedge CLK);
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL retrigger_busy_late got %b want 0", BUSY); end
   endtask

   task automatic test_cmd1_update;
      logic [15:0] d;
      wr(A_CR1, 16'h0100, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      wr(A_CR1, 16'h7500, 2'b11);
      repeat (LAT) @(negedge CLK);
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL abort_rr2 got %h want %h", d, 16'h0000); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0081) begin failed++; $display("FAIL abort_hirq got %h want %h", d, 16'h0081); end
      wr(A_CR1, 16'h0100, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      repeat (LAT + 1) @(negedge CLK);
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h0002) begin failed++; $display("FAIL hwinfo_rr2 got %h want %h", d, 16'h0002); end
      rd(A_CR4, d); tests_run++;
      if (d !== 16'h0600) begin failed++; $display("FAIL hwinfo_rr4 got %h want %h", d, 16'h0600); end
   endtask

   task automatic test_clear_set_collision;
      logic [15:0] d;
      wr(A_CR1, 16'h0200, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      repeat (LAT) @(negedge CLK);
      wr(A_HIRQ, 16'h0000, 2'b11);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0003) begin failed++; $display("FAIL collide_hirq got %h want %h", d, 16'h0003); end
   endtask

   task automatic test_lanes_decode;
      logic [15:0] d;
      wr(A_MASK, 16'h00AA, 2'b01);
      rd(A_MASK, d); tests_run++;
      if (d !== 16'hFFAA) begin failed++; $display("FAIL mask_lower got %h want %h", d, 16'hFFAA); end
      wr(A_MASK, 16'h5500, 2'b10);
      rd(A_MASK, d); tests_run++;
      if (d !== 16'h55AA) begin failed++; $display("FAIL mask_upper got %h want %h", d, 16'h55AA); end
      wr(A_MASK, 16'hFFFF, 2'b11);
      rd_raw(1'b1, {PAGE, A_CR1[15:1]}, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL unselected_do got %h want %h", d, 16'h0000); end
      rd_raw(1'b0, {10'h188, A_CR1[15:1]}, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL wrong_page_do got %h want %h", d, 16'h0000); end
      rd(16'h0010, d); tests_run++;
      if (d !== 16'h0000) begin failed++; $display("FAIL unmapped_do got %h want %h", d, 16'h0000); end
      bus.ACS2_N = 1'b0; bus.AA = {10'h188, A_HIRQ[15:1]}; bus.DI = 16'h0000;
      bus.AWRU_N = 1'b0; bus.AWRL_N = 1'b0;
      @(negedge CLK);
      bus.ACS2_N = 1'b1; bus.AWRU_N = 1'b1; bus.AWRL_N = 1'b1;
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0003) begin failed++; $display("FAIL wrong_page_write got %h want %h", d, 16'h0003); end
   endtask

   task automatic test_ce_stall;
      logic [15:0] d;
      wr(A_CR1, 16'h0000, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      CE_R = 1'b0;
      wr(A_HIRQ, 16'h0000, 2'b11);
      repeat (2) @(negedge CLK);
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0002) begin failed++; $display("FAIL stall_hirq got %h want %h", d, 16'h0002); end
      CE_R = 1'b1;
      repeat (LAT) @(negedge CLK);
      tests_run++;
      if (BUSY !== 1'b1) begin failed++; $display("FAIL stall_busy got %b want 1", BUSY); end
      @(negedge CLK);
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL stall_done got %b want 0", BUSY); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0003) begin failed++; $display("FAIL stall_hirq_done got %h want %h", d, 16'h0003); end
   endtask

   task automatic test_rst_mid_command;
      logic [15:0] d;
      wr(A_CR1, 16'h0200, 2'b11);
      wr(A_CR4, 16'h0000, 2'b11);
      repeat (2) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL rst_busy got %b want 0", BUSY); end
      rd(A_HIRQ, d); tests_run++;
      if (d !== 16'h0001) begin failed++; $display("FAIL rst_hirq got %h want %h", d, 16'h0001); end
      @(negedge CLK);
      RST = 1'b0;
      repeat (LAT + 3) @(negedge CLK);
      rd(A_CR1, d); tests_run++;
      if (d !== 16'h0043) begin failed++; $display("FAIL rst_rr1 got %h want %h", d, 16'h0043); end
      rd(A_CR2, d); tests_run++;
      if (d !== 16'h4442) begin failed++; $display("FAIL rst_rr2 got %h want %h", d, 16'h4442); end
      tests_run++;
      if (BUSY !== 1'b0) begin failed++; $display("FAIL rst_busy_late got %b want 0", BUSY); end
   endtask

   initial begin
      tests_run  = 0;
      failed     = 0;
      RST        = 1'b0;
      CE_R       = 1'b1;
      bus.ACS2_N = 1'b1;
      bus.AA     = '0;
      bus.AWRU_N = 1'b1;
      bus.AWRL_N = 1'b1;
      bus.ARD_N  = 1'b1;
      bus.DI     = 16'h0000;
      @(negedge CLK);
      test_reset();
      test_hirq_clear();
      test_masked_status();
      test_get_toc();
      test_periodic();
      test_unknown_retrigger();
      test_cmd1_update();
      test_clear_set_collision();
      test_lanes_decode();
      test_ce_stall();
      test_rst_mid_command();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
